spi_reg_bridge: RTL
===================

Name: spi_reg_bridge

Overview:
SPI slave front-end that turns serial host frames into the single-cycle register-bus strobes (wen/ren/addr/wdata) consumed by every rw_reg-style register instance, and returns the read data (OR of all register rdata outputs) on MISO. It sits directly upstream of the register bank. All SPI pins are oversampled in the i_clk domain, so no SCLK clock domain exists.

Parameters:
AW, 8, register address width
DW, 8, register data width
SYNC_STAGES, 2, synchronizer flops on csb/sclk/mosi (min 2)

Ports:
i_clk  input  1  system clock; SCLK must be <= i_clk/8
i_rst_n  input  1  async active-low reset
i_spi_csb  input  1  chip select, active low
i_spi_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
i_spi_mosi  input  1  serial data in, MSB first
o_spi_miso  output  1  serial data out
o_spi_miso_oe  output  1  MISO pad output enable
o_wen  output  1  register write strobe, 1-cycle pulse
o_ren  output  1  register read strobe, 1-cycle pulse
o_addr  output  AW  register address, held until next frame's address completes
o_wdata  output  DW  write data, valid with o_wen
i_rdata  input  DW  OR-combined register read data, valid combinationally while o_ren=1
o_frame_err  output  1  1-cycle pulse on parity error or truncated frame

Behaviour:
- Reset: i_rst_n async, active-low; clock i_clk. All outputs 0, FSM in IDLE, shift/bit counters cleared, synchronizers cleared to csb=1, sclk=0, mosi=0.
- Frame (N = AW+DW+2 bits, MSB first): rw (1=write, 0=read), addr[AW-1:0], data[DW-1:0], parity. Even parity: total count of 1s over all N bits is even. For reads, the data bits on MOSI are don't-care and excluded; parity covers rw+addr+parity bit.
- Sampling: MOSI captured on the synchronized SCLK rising edge; MISO updated on the synchronized falling edge.
- FSM: IDLE -> CMD on synced csb falling. CMD shifts 1+AW bits -> DATA. DATA shifts DW bits -> PAR. PAR samples 1 bit -> DONE. DONE ignores further SCLK edges until csb rises -> IDLE.
- Read: on the cycle after the last address bit is sampled, o_addr updated and o_ren=1 for exactly one cycle; i_rdata captured into the tx shift register in that same cycle. Data MSB is driven on MISO at the next falling edge; subsequent bits on each following falling edge. o_spi_miso_oe=1 only in DATA of a read frame while csb low; otherwise MISO=0 and OE=0.
- Write: no bus activity until PAR. The cycle after the parity bit is sampled: if parity is correct, o_addr/o_wdata updated and o_wen=1 for one cycle; if parity is wrong, no write and o_frame_err=1 for one cycle.
- Read parity error: o_ren has already fired; only o_frame_err pulses, in the cycle after the parity bit.
- Truncation: csb rising in CMD/DATA/PAR -> abort to IDLE, no o_wen, o_frame_err pulse, o_spi_miso_oe drops the same cycle.
- Extra bits after DONE are ignored, with no second strobe.
- o_wen and o_ren are never high in the same cycle. At most one strobe per frame.
- Bit counter is sized $clog2(N+1) and is cleared on every csb falling edge.
- Back-to-back frames require csb high for >= 2 synced samples; shorter glitches are not guaranteed to be detected.

Test Plan:
- Write: rw=1, addr=0x12, data=0xA5, parity=1 -> single o_wen with o_addr=0x12, o_wdata=0xA5; o_frame_err stays 0.
- Read: rw=0, addr=0x34, parity=1, i_rdata=0x5A during o_ren -> one o_ren pulse with o_addr=0x34; MISO shifts 0,1,0,1,1,0,1,0 with OE high for exactly 8 bits.
- Parity error: write addr=0x12, data=0xA5, parity=0 -> no o_wen, one o_frame_err pulse.
- Truncated frame: csb rises after 10 bits of a write -> no o_wen, o_frame_err pulse, FSM in IDLE; the next valid write succeeds.
- Reset mid-frame: assert i_rst_n low during DATA -> all outputs 0 immediately; after release, a fresh write to 0x01 with data 0xFF and correct parity completes normally.
- Back-to-back: write 0x05/0x3C then read 0x05 with csb high for 2 clocks between -> exactly one o_wen then one o_ren; 20 extra SCLK pulses after DONE cause no additional strobes.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI mode-0 slave to single-cycle register bus bridge
module spi_reg_bridge #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_spi_csb,
  input  logic          i_spi_sclk,
  input  logic          i_spi_mosi,
  output logic          o_spi_miso,
  output logic          o_spi_miso_oe,
  output logic          o_wen,
  output logic          o_ren,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  input  logic [DW-1:0] i_rdata,
  output logic          o_frame_err
);

  localparam int N  = AW + DW + 2;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CMD  = CW'(AW);
  localparam logic [CW-1:0] LAST_DATA = CW'(AW + DW);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] csb_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   csb_prev_q, sclk_prev_q;
  logic                   csb_s, sclk_s, mosi_s;
  logic                   csb_fall, csb_rise, sclk_rise, sclk_fall;

  logic [CW-1:0] bit_cnt_q;
  logic          rw_q;
  logic          par_q;
  logic [AW-1:0] addr_sr_q;
  logic [DW-1:0] data_sr_q;
  logic [DW-1:0] tx_sr_q;
  logic          miso_q;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  assign csb_s  = csb_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign csb_fall  = ~csb_s & csb_prev_q;
  assign csb_rise  = csb_s & ~csb_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // Bring the SPI pins into the i_clk domain and keep one delayed copy for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      csb_sync_q  <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csb_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], i_spi_csb};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
      csb_prev_q  <= csb_s;
      sclk_prev_q <= sclk_s;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the strobe decisions; a csb rise always wins over a coincident sclk edge
  always_comb begin
    state_d = state_q;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (csb_fall) state_d = CMD;
      end
      CMD: begin
        if (csb_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise && (bit_cnt_q == LAST_CMD)) begin
          state_d = DATA;
          ren_d   = ~rw_q;
        end
      end
      DATA: begin
        if (csb_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise && (bit_cnt_q == LAST_DATA)) begin
          state_d = PAR;
        end
      end
      PAR: begin
        if (csb_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          state_d = DONE;
          if (par_q ^ mosi_s) err_d = 1'b1;
          else                wen_d = rw_q;
        end
      end
      DONE: begin
        if (csb_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Receive path: bit counter, rw/address/data shifters and running parity
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt_q <= '0;
      rw_q      <= 1'b0;
      par_q     <= 1'b0;
      addr_sr_q <= '0;
      data_sr_q <= '0;
    end else if (csb_fall) begin
      bit_cnt_q <= '0;
      rw_q      <= 1'b0;
      par_q     <= 1'b0;
    end else if (sclk_rise && !csb_rise) begin
      if (state_q == CMD) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        par_q     <= par_q ^ mosi_s;
        if (bit_cnt_q == '0) rw_q <= mosi_s;
        else                 addr_sr_q <= {addr_sr_q[AW-2:0], mosi_s};
      end else if (state_q == DATA) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        data_sr_q <= {data_sr_q[DW-2:0], mosi_s};
        // Read-frame data bits are don't-care and stay out of the parity
        if (rw_q) par_q <= par_q ^ mosi_s;
      end else if (state_q == PAR) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  // Register-bus outputs: strobes are registered so each lasts exactly one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= wen_d;
      ren_q <= ren_d;
      err_q <= err_d;
      if (ren_d) addr_q <= {addr_sr_q[AW-2:0], mosi_s};
      if (wen_d) begin
        addr_q  <= addr_sr_q;
        wdata_q <= data_sr_q;
      end
    end
  end

  // Transmit path: load read data during the ren cycle, shift MSB first on sclk falls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_sr_q <= '0;
      miso_q  <= 1'b0;
    end else if (csb_fall) begin
      miso_q <= 1'b0;
    end else if (ren_q) begin
      tx_sr_q <= i_rdata;
    end else if (sclk_fall && (state_q == DATA) && !rw_q) begin
      miso_q  <= tx_sr_q[DW-1];
      tx_sr_q <= {tx_sr_q[DW-2:0], 1'b0};
    end
  end

  assign o_spi_miso_oe = (state_q == DATA) && !rw_q && !csb_s;
  assign o_spi_miso    = o_spi_miso_oe & miso_q;
  assign o_wen         = wen_q;
  assign o_ren         = ren_q;
  assign o_frame_err   = err_q;
  assign o_addr        = addr_q;
  assign o_wdata       = wdata_q;

endmodule
